// File: rtl/ternary_neuron_pkg.sv
// Shared types and constants for the ternary neuron accumulate-and-threshold stage.
package ternary_neuron_pkg;

   typedef logic [1:0] trit_t;

   localparam trit_t TRIT_POS  = 2'b01;
   localparam trit_t TRIT_NEG  = 2'b11;
   localparam trit_t TRIT_ZERO = 2'b00;

   typedef enum logic {
      ACC = 1'b0,
      OUT = 1'b1
   } tna_state_t;

   localparam int unsigned PC_W   = 5;
   localparam int unsigned PC_MAX = 18;

endpackage : ternary_neuron_pkg

// File: rtl/ternary_neuron_acc_if.sv
// Popcount-beat input and ternary-result output handshakes of one ternary neuron stage.
interface ternary_neuron_acc_if #(
   parameter int unsigned ACC_W = 10
);
   import ternary_neuron_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic [PC_W-1:0]         pc_pos;
   logic [PC_W-1:0]         pc_neg;
   logic signed [ACC_W-1:0] th_hi;
   logic signed [ACC_W-1:0] th_lo;
   logic                    out_valid;
   logic                    out_ready;
   trit_t                   out_trit;
   logic signed [ACC_W-1:0] out_sum;

   modport master (
      output in_valid, pc_pos, pc_neg, th_hi, th_lo, out_ready,
      input  in_ready, out_valid, out_trit, out_sum
   );

   modport slave (
      input  in_valid, pc_pos, pc_neg, th_hi, th_lo, out_ready,
      output in_ready, out_valid, out_trit, out_sum
   );

endinterface : ternary_neuron_acc_if

// File: rtl/tna_threshold.sv
// Combinational two-threshold compare of a signed sum into a trit; +1 wins when th_lo >= th_hi.
module tna_threshold
   import ternary_neuron_pkg::*;
#(
   parameter int unsigned W = 10
) (
   input  logic signed [W-1:0] sum_i,
   input  logic signed [W-1:0] th_hi_i,
   input  logic signed [W-1:0] th_lo_i,
   output trit_t               trit_o
);

   always_comb begin
      trit_o = TRIT_ZERO;
      if (sum_i >= th_hi_i) begin
         trit_o = TRIT_POS;
      end else if (sum_i <= th_lo_i) begin
         trit_o = TRIT_NEG;
      end
   end

endmodule : tna_threshold

// File: rtl/ternary_neuron_acc.sv
// Accumulates pc_pos - pc_neg over N_BEATS beats, then thresholds the total into one trit.
// Build option: TNA_SAT_EN saturates the running sum instead of wrapping it.
module ternary_neuron_acc
   import ternary_neuron_pkg::*;
#(
   parameter int unsigned N_BEATS = 4,
   parameter int unsigned ACC_W   = 10
) (
   input logic                  clk,
   input logic                  rst,
   ternary_neuron_acc_if.slave  bus
);

   localparam int unsigned CNT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
   localparam int unsigned DIFF_W = PC_W + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

   tna_state_t              state_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
   trit_t                   trit_q;
   logic signed [ACC_W-1:0] sum_q;

   logic signed [DIFF_W-1:0] diff_c;
   logic signed [ACC_W-1:0]  nxt_d;
   trit_t                    trit_c;

`ifdef TNA_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   logic signed [ACC_W:0] wide_c;

   // One guard bit exposes overflow; clamp to the signed range.
   always_comb begin
      diff_c = $signed({1'b0, bus.pc_pos}) - $signed({1'b0, bus.pc_neg});
      wide_c = (ACC_W+1)'(acc_q) + (ACC_W+1)'(diff_c);
      nxt_d  = wide_c[ACC_W-1:0];
      if (wide_c[ACC_W] != wide_c[ACC_W-1]) begin
         nxt_d = wide_c[ACC_W] ? SAT_MIN : SAT_MAX;
      end
   end
`else
   // Two's-complement wrap at ACC_W.
   always_comb begin
      diff_c = $signed({1'b0, bus.pc_pos}) - $signed({1'b0, bus.pc_neg});
      nxt_d  = acc_q + ACC_W'(diff_c);
   end
`endif

   tna_threshold #(
      .W (ACC_W)
   ) u_threshold (
      .sum_i   (nxt_d),
      .th_hi_i (bus.th_hi),
      .th_lo_i (bus.th_lo),
      .trit_o  (trit_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         trit_q      <= TRIT_ZERO;
         sum_q       <= '0;
      end else begin
         case (state_q)
            ACC: begin
               if (bus.in_valid && in_ready_q) begin
                  if (cnt_q == LAST_BEAT) begin
                     sum_q       <= nxt_d;
                     trit_q      <= trit_c;
                     acc_q       <= '0;
                     cnt_q       <= '0;
                     state_q     <= OUT;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     acc_q <= nxt_d;
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  state_q     <= ACC;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= ACC;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_trit  = trit_q;
   assign bus.out_sum   = sum_q;

endmodule : ternary_neuron_acc

// File: tb/tb_ternary_neuron_acc.sv
// Self-checking bench: default stage (ACC_W=10) plus a narrow stage (ACC_W=6) for overflow handling.
module tb_ternary_neuron_acc;
   import ternary_neuron_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ternary_neuron_acc_if #(.ACC_W(10)) if0 ();
   ternary_neuron_acc_if #(.ACC_W(6))  if1 ();

   ternary_neuron_acc #(.N_BEATS(4), .ACC_W(10)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   ternary_neuron_acc #(.N_BEATS(4), .ACC_W(6))  dut1 (.clk(clk), .rst(rst), .bus(if1));

   int checks   = 0;
   int failures = 0;
   int bp[16];
   int bn[16];
   int th_hi_v;
   int th_lo_v;

   // Reference: integer sum of beat differences, clamped per beat or wrapped at the end.
   function automatic void ref_eval(input int n, input int w, output int sum, output logic [1:0] trit);
      int mx;
      int mn;
      int m;
      mx  = (1 << (w - 1)) - 1;
      mn  = -(1 << (w - 1));
      m   = 1 << w;
      sum = 0;
      for (int i = 0; i < n; i++) begin
         sum = sum + bp[i] - bn[i];
`ifdef TNA_SAT_EN
         if (sum > mx) sum = mx;
         if (sum < mn) sum = mn;
`endif
      end
`ifndef TNA_SAT_EN
      sum = ((sum % m) + m) % m;
      if (sum > mx) sum = sum - m;
`endif
      if (sum >= th_hi_v)      trit = 2'b01;
      else if (sum <= th_lo_v) trit = 2'b11;
      else                     trit = 2'b00;
   endfunction

   // Drives n beats into dut0 starting at a negedge; returns at the negedge after the last accept.
   task automatic drive_eval0(input int n, input bit bubbles, output bit lat_ok);
      lat_ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (bubbles && $urandom_range(0, 2) == 0) begin
            if0.in_valid = 1'b0;
            @(negedge clk);
         end
         if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) lat_ok = 1'b0;
         if0.in_valid = 1'b1;
         if0.pc_pos   = 5'(bp[i]);
         if0.pc_neg   = 5'(bn[i]);
         if (i == n - 1) begin
            if0.th_hi = 10'(th_hi_v);
            if0.th_lo = 10'(th_lo_v);
         end else begin
            if0.th_hi = 10'($urandom_range(0, 1023));
            if0.th_lo = 10'($urandom_range(0, 1023));
         end
         @(negedge clk);
      end
      if0.in_valid = 1'b0;
      if (if0.out_valid !== 1'b1) lat_ok = 1'b0;
   endtask

   task automatic drive_eval1(input int n);
      for (int i = 0; i < n; i++) begin
         if1.in_valid = 1'b1;
         if1.pc_pos   = 5'(bp[i]);
         if1.pc_neg   = 5'(bn[i]);
         if1.th_hi    = 6'(th_hi_v);
         if1.th_lo    = 6'(th_lo_v);
         @(negedge clk);
      end
      if1.in_valid = 1'b0;
   endtask

   task automatic consume_both();
      if0.out_ready = 1'b1;
      if1.out_ready = 1'b1;
      @(negedge clk);
      if0.out_ready = 1'b0;
      if1.out_ready = 1'b0;
   endtask

   task automatic set_beats(input int p, input int q);
      for (int i = 0; i < 16; i++) begin
         bp[i] = p;
         bn[i] = q;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if0.in_valid = 1'b0; if0.out_ready = 1'b0; if0.pc_pos = '0; if0.pc_neg = '0;
      if0.th_hi = '0; if0.th_lo = '0;
      if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.pc_pos = '0; if1.pc_neg = '0;
      if1.th_hi = '0; if1.th_lo = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({if0.in_ready, if0.out_valid, if0.out_trit, if0.out_sum} !== {1'b1, 1'b0, 2'b00, 10'd0}) begin
         failures++;
         $display("FAIL reset0 got rdy=%b vld=%b trit=%b sum=%0d want 1 0 00 0",
                  if0.in_ready, if0.out_valid, if0.out_trit, if0.out_sum);
      end
      checks++;
      if ({if1.in_ready, if1.out_valid, if1.out_trit, if1.out_sum} !== {1'b1, 1'b0, 2'b00, 6'd0}) begin
         failures++;
         $display("FAIL reset1 got rdy=%b vld=%b trit=%b sum=%0d want 1 0 00 0",
                  if1.in_ready, if1.out_valid, if1.out_trit, if1.out_sum);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      int exp_sum;
      logic [1:0] exp_trit;
      bit lat_ok;
      th_hi_v = 4;
      th_lo_v = -4;
      for (int c = 0; c < 5; c++) begin
         case (c)
            0: begin bp[0]=5; bn[0]=1; bp[1]=3; bn[1]=3; bp[2]=2; bn[2]=0; bp[3]=0; bn[3]=0; end
            1: set_beats(0, 5);
            2: set_beats(1, 0);
            3: set_beats(0, 1);
            default: begin set_beats(1, 0); bp[3] = 0; end
         endcase
         ref_eval(4, 10, exp_sum, exp_trit);
         drive_eval0(4, 1'b0, lat_ok);
         checks++;
         if (!lat_ok) begin
            failures++;
            $display("FAIL directed%0d_latency got out_valid=%b want 1 right after 4th beat", c, if0.out_valid);
         end
         checks++;
         if (if0.out_trit !== exp_trit || int'(if0.out_sum) != exp_sum) begin
            failures++;
            $display("FAIL directed%0d_result got trit=%b sum=%0d want trit=%b sum=%0d",
                     c, if0.out_trit, if0.out_sum, exp_trit, exp_sum);
         end
         consume_both();
      end
   endtask

   task automatic test_hold();
      int exp_sum;
      logic [1:0] exp_trit;
      bit lat_ok;
      th_hi_v = 4;
      th_lo_v = -4;
      set_beats(3, 0);
      ref_eval(4, 10, exp_sum, exp_trit);
      drive_eval0(4, 1'b0, lat_ok);
      if0.in_valid = 1'b1;
      if0.pc_pos   = 5'd7;
      if0.pc_neg   = 5'd0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1 || if0.out_trit !== exp_trit
             || int'(if0.out_sum) != exp_sum) begin
            failures++;
            $display("FAIL hold%0d got rdy=%b vld=%b trit=%b sum=%0d want 0 1 %b %0d",
                     k, if0.in_ready, if0.out_valid, if0.out_trit, if0.out_sum, exp_trit, exp_sum);
         end
      end
      if0.in_valid = 1'b0;
      consume_both();
      bp[0]=1; bn[0]=1; bp[1]=2; bn[1]=0; bp[2]=0; bn[2]=3; bp[3]=1; bn[3]=0;
      ref_eval(4, 10, exp_sum, exp_trit);
      drive_eval0(4, 1'b0, lat_ok);
      checks++;
      if (!lat_ok || if0.out_trit !== exp_trit || int'(if0.out_sum) != exp_sum) begin
         failures++;
         $display("FAIL after_hold got lat=%b trit=%b sum=%0d want 1 %b %0d",
                  lat_ok, if0.out_trit, if0.out_sum, exp_trit, exp_sum);
      end
      consume_both();
   endtask

   task automatic test_random();
      int exp_sum;
      logic [1:0] exp_trit;
      bit lat_ok;
      for (int e = 0; e < 40; e++) begin
         for (int i = 0; i < 4; i++) begin
            bp[i] = int'($urandom_range(0, PC_MAX));
            bn[i] = int'($urandom_range(0, PC_MAX));
         end
         th_hi_v = int'($urandom_range(0, 80)) - 40;
         if ($urandom_range(0, 4) == 0) th_lo_v = int'($urandom_range(0, 80)) - 40;
         else                           th_lo_v = th_hi_v - int'($urandom_range(0, 40));
         ref_eval(4, 10, exp_sum, exp_trit);
         drive_eval0(4, 1'b1, lat_ok);
         checks++;
         if (!lat_ok || if0.out_trit !== exp_trit || int'(if0.out_sum) != exp_sum) begin
            failures++;
            $display("FAIL random%0d got lat=%b trit=%b sum=%0d want 1 %b %0d (hi=%0d lo=%0d)",
                     e, lat_ok, if0.out_trit, if0.out_sum, exp_trit, exp_sum, th_hi_v, th_lo_v);
         end
         consume_both();
      end
   endtask

   task automatic test_back_to_back();
      int exp_sum;
      logic [1:0] exp_trit;
      bit lat_ok;
      if0.out_ready = 1'b1;
      th_hi_v = 10;
      th_lo_v = -10;
      for (int e = 0; e < 3; e++) begin
         for (int i = 0; i < 4; i++) begin
            bp[i] = int'($urandom_range(0, PC_MAX));
            bn[i] = int'($urandom_range(0, PC_MAX));
         end
         ref_eval(4, 10, exp_sum, exp_trit);
         drive_eval0(4, 1'b0, lat_ok);
         checks++;
         if (!lat_ok || if0.out_trit !== exp_trit || int'(if0.out_sum) != exp_sum) begin
            failures++;
            $display("FAIL b2b%0d got lat=%b trit=%b sum=%0d want 1 %b %0d",
                     e, lat_ok, if0.out_trit, if0.out_sum, exp_trit, exp_sum);
         end
         @(negedge clk);
         checks++;
         if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b%0d_turnaround got rdy=%b vld=%b want 1 0", e, if0.in_ready, if0.out_valid);
         end
      end
      if0.out_ready = 1'b0;
   endtask

   task automatic test_narrow();
      int exp_sum;
      logic [1:0] exp_trit;
      th_hi_v = 20;
      th_lo_v = -4;
      for (int e = 0; e < 9; e++) begin
         if (e == 0) begin
            set_beats(18, 0);
         end else begin
            for (int i = 0; i < 4; i++) begin
               bp[i] = int'($urandom_range(0, PC_MAX));
               bn[i] = int'($urandom_range(0, PC_MAX));
            end
            th_hi_v = int'($urandom_range(0, 40)) - 20;
            th_lo_v = th_hi_v - int'($urandom_range(0, 10));
         end
         ref_eval(4, 6, exp_sum, exp_trit);
`ifdef TNA_SAT_EN
         if (e == 0 && (exp_sum != 31 || exp_trit != 2'b01)) $fatal(1, "FAIL narrow model disagrees with plan");
`else
         if (e == 0 && (exp_sum != 8 || exp_trit != 2'b00)) $fatal(1, "FAIL narrow model disagrees with plan");
`endif
         drive_eval1(4);
         checks++;
         if (if1.out_valid !== 1'b1 || if1.out_trit !== exp_trit || int'(if1.out_sum) != exp_sum) begin
            failures++;
            $display("FAIL narrow%0d got vld=%b trit=%b sum=%0d want 1 %b %0d",
                     e, if1.out_valid, if1.out_trit, if1.out_sum, exp_trit, exp_sum);
         end
         consume_both();
      end
   endtask

   task automatic test_reset_abort();
      int exp_sum;
      logic [1:0] exp_trit;
      bit lat_ok;
      if0.in_valid = 1'b1;
      if0.pc_pos   = 5'd9;
      if0.pc_neg   = 5'd0;
      repeat (2) @(negedge clk);
      if0.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      th_hi_v = 4;
      th_lo_v = -4;
      set_beats(1, 0);
      ref_eval(4, 10, exp_sum, exp_trit);
      drive_eval0(4, 1'b0, lat_ok);
      checks++;
      if (!lat_ok || if0.out_trit !== exp_trit || int'(if0.out_sum) != exp_sum) begin
         failures++;
         $display("FAIL reset_abort got lat=%b trit=%b sum=%0d want 1 %b %0d",
                  lat_ok, if0.out_trit, if0.out_sum, exp_trit, exp_sum);
      end
      consume_both();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_random();
      test_back_to_back();
      test_narrow();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ternary_neuron_acc

// File: doc/ternary_neuron_acc.md
# ternary_neuron_acc

Sequential accumulate-and-threshold stage for the ternary neurons of the printed-NN datapath. It sits directly downstream of a pair of 18-input popcount units: one counts inputs with +1 weights, the other counts inputs with −1 weights. Over N_BEATS handshaked beats it accumulates the signed difference of the two popcounts. It then compares the total against two runtime thresholds and emits one ternary activation.

## Interface
- N_BEATS, 4: popcount beats per neuron evaluation; legal range 1..16.
- ACC_W, 10: signed accumulator width; legal range 6..16.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a popcount beat is presented.
- in_ready  out  1  the stage accepts a beat.
- pc_pos  in  5  unsigned popcount of the +1-weighted inputs, 0..18.
- pc_neg  in  5  unsigned popcount of the −1-weighted inputs, 0..18.
- th_hi  in  ACC_W  signed upper threshold.
- th_lo  in  ACC_W  signed lower threshold; th_lo ≤ th_hi is required of software, and the block does not check it.
- out_valid  out  1  a result is held.
- out_ready  in  1  the consumer takes the result.
- out_trit  out  2  ternary result: 2'b01 = +1, 2'b11 = −1, 2'b00 = 0; 2'b10 is never driven.
- out_sum  out  ACC_W  signed final accumulator value, for debug and calibration.

## Operation
- State machine: ACC and OUT. Reset enters ACC with acc=0 and beat_cnt=0.
- ACC state:
  - in_ready=1 and out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - diff = $signed({1'b0,pc_pos}) − $signed({1'b0,pc_neg}). It is 6-bit signed (range −18..+18) and sign-extended to ACC_W.
  - nxt = acc + diff, computed at ACC_W. Overflow behaviour is set by the Configuration section.
- Accepted beat that is not the last (beat_cnt < N_BEATS−1): acc←nxt, beat_cnt++.
- Accepted last beat (beat_cnt = N_BEATS−1):
  - out_sum←nxt.
  - out_trit←+1 if nxt ≥ th_hi; else −1 if nxt ≤ th_lo; else 0. The +1 test has priority when th_lo ≥ th_hi.
  - acc←0, beat_cnt←0, state←OUT.
  - th_hi and th_lo are sampled only in this cycle.
- OUT state:
  - in_ready=0 and out_valid=1. out_trit and out_sum are held stable until out_ready.
  - out_valid && out_ready returns to ACC. The next beat is accepted the following cycle at the earliest.
- Beats with pc_pos or pc_neg > 18 are out of contract. Their arithmetic still follows the width rules above.
- Reset during ACC or OUT discards any partial sum and any pending result.

## Timing
- Reset values: in_ready=1, out_valid=0, out_trit=2'b00, out_sum=0.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. 1 cycle after the last in_valid&&in_ready cycle.
- Throughput: one evaluation per N_BEATS+1 cycles when out_ready is held high.
- in_ready is a registered function of state and has no combinational path from out_ready.
- There is no combinational path from inputs to out_*.

## Configuration
- TNA_SAT_EN defined: nxt saturates to the ACC_W signed limits, +(2^(ACC_W−1)−1) and −2^(ACC_W−1). The saturated value is both stored and compared.
- TNA_SAT_EN undefined: nxt wraps modulo 2^ACC_W (two's complement), which gives a smaller area. With defaults the worst case is N_BEATS·18 = 72, so no overflow occurs.

## Structure
- Package ternary_neuron_pkg holds:
  - trit_t (2-bit) and the constants TRIT_POS=2'b01, TRIT_NEG=2'b11, TRIT_ZERO=2'b00.
  - The state enum tna_state_t {ACC, OUT}.
  - PC_W=5 and PC_MAX=18.
- One sub-module, tna_threshold, is natural: a combinational compare of a signed sum against th_hi/th_lo that produces a trit_t. It is reused by future multi-neuron wrappers.

## Test plan
- Defaults; thresholds th_hi=4, th_lo=−4. Beats (pos,neg) = (5,1),(3,3),(2,0),(0,0): sum 6, so out_trit=01 and out_sum=6, with out_valid asserted the cycle after the 4th beat.
- Beats (0,5)×4: sum −20, so out_trit=11 and out_sum=−20.
- Beats giving sum exactly 4, then in a second evaluation exactly −4: out_trit=01, then out_trit=11 (boundaries inclusive). Beats giving sum 3 yield out_trit=00.
- Hold out_ready=0 for 5 cycles while in_valid=1: in_ready stays 0, no beat is consumed, and out_trit/out_sum remain stable.
- ACC_W=6, N_BEATS=4, beats (18,0)×4:
  - With TNA_SAT_EN defined: out_sum=31 and out_trit=+1 for th_hi=20.
  - Without it: out_sum = 72 mod 64 = 8, and out_trit=0 for th_hi=20, th_lo=−4.
- Assert rst after 2 beats, then release and apply 4 new beats of (1,0): out_sum=4, with no residue from the aborted evaluation.
